// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// Define MDU_DIV_EN to build the restoring divider (DIVU/DIV).
module mult_div_unit (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic [31:0] RSdata_i,
   input  logic [31:0] RTdata_i,
   input  logic        mthi_i,
   input  logic        mtlo_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] HI_o,
   output logic [31:0] LO_o
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q;
   logic [31:0] a_q;
   logic [63:0] prod_q, prod_d, res;
   logic        neg_q;
   logic        accept, op_ok, move_ok;
   logic        sa, sb;
   logic [31:0] mag_rs, mag_rt;
   logic [32:0] mul_sum;
   logic [63:0] mul_next;

`ifdef MDU_DIV_EN
   logic        is_div_q, rneg_q;
   logic [32:0] div_shift;
   logic        div_ge;
   logic [31:0] div_rem;
   logic [63:0] div_next;
   assign op_ok = 1'b1;
`else
   assign op_ok = ~op_i[1];
`endif

   assign sa     = op_i[0] & RSdata_i[31];
   assign sb     = op_i[0] & RTdata_i[31];
   assign mag_rs = sa ? -RSdata_i : RSdata_i;
   assign mag_rt = sb ? -RTdata_i : RTdata_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      busy_o  = (state_q == CALC);
      done_o  = (state_q == DONE);
      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start_i && op_ok) begin
               accept  = 1'b1;
               state_d = CALC;
            end
         end
         CALC: if (cnt_q == 5'd31) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   assign move_ok = (state_q != CALC) && !accept;

   // Shift-add: multiplier sits in the low half, product grows from the top.
   assign mul_sum  = {1'b0, prod_q[63:32]} +
                     (prod_q[0] ? {1'b0, a_q} : 33'd0);
   assign mul_next = {mul_sum, prod_q[31:1]};

`ifdef MDU_DIV_EN
   // Restoring step: remainder in the high half, quotient shifts into low.
   assign div_shift = {prod_q[63:32], prod_q[31]};
   assign div_ge    = div_shift >= {1'b0, a_q};
   assign div_rem   = div_shift[31:0] - a_q;
   assign div_next  = {div_ge ? div_rem : div_shift[31:0],
                       prod_q[30:0], div_ge};
`endif

   always_comb begin
      prod_d = mul_next;
      res    = neg_q ? -prod_d : prod_d;
`ifdef MDU_DIV_EN
      if (is_div_q) begin
         prod_d = div_next;
         res    = {rneg_q ? -prod_d[63:32] : prod_d[63:32],
                   neg_q  ? -prod_d[31:0]  : prod_d[31:0]};
      end
`endif
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q    <= '0;
         a_q      <= '0;
         prod_q   <= '0;
         neg_q    <= 1'b0;
         HI_o     <= '0;
         LO_o     <= '0;
`ifdef MDU_DIV_EN
         is_div_q <= 1'b0;
         rneg_q   <= 1'b0;
`endif
      end else begin
         if (accept) begin
            cnt_q  <= '0;
            a_q    <= mag_rs;
            prod_q <= {32'd0, mag_rt};
            neg_q  <= sa ^ sb;
`ifdef MDU_DIV_EN
            is_div_q <= op_i[1];
            rneg_q   <= sa;
            // Divide by zero keeps an all-ones quotient unsigned.
            if (op_i[1]) begin
               a_q    <= mag_rt;
               prod_q <= {32'd0, mag_rs};
               neg_q  <= (sa ^ sb) & (|RTdata_i);
            end
`endif
         end else if (state_q == CALC) begin
            prod_q <= prod_d;
            cnt_q  <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               HI_o <= res[63:32];
               LO_o <= res[31:0];
            end
         end
         if (move_ok) begin
            if (mthi_i) HI_o <= RSdata_i;
            if (mtlo_i) LO_o <= RSdata_i;
         end
      end
   end

endmodule
